// File: rtl/uart_cmd_rx_pkg.sv
// uart_cmd_rx_pkg: command bytes, payload size and state encodings shared by the PC-link receiver
package uart_cmd_rx_pkg;
  localparam logic [7:0] CMD_TEST    = 8'h54;
  localparam logic [7:0] CMD_READCF  = 8'h43;
  localparam logic [7:0] CMD_READSET = 8'h53;
  localparam logic [7:0] CMD_READCPS = 8'h50;
  localparam logic [7:0] CMD_WRSET   = 8'h57;
  localparam logic [7:0] CMD_CR      = 8'h0D;
  localparam logic [7:0] CMD_LF      = 8'h0A;
  localparam int SETTING_BYTES = 16;
  typedef enum logic [1:0] {D_IDLE, D_PAYLOAD, D_COMMIT} dec_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  function automatic logic is_known(input logic [7:0] b);
    return b inside {CMD_TEST, CMD_READCF, CMD_READSET, CMD_READCPS, CMD_WRSET, CMD_CR, CMD_LF};
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 deserialiser with 2-FF synchroniser, mid-bit sampling and framing check
module uart_rx_byte
  import uart_cmd_rx_pkg::*;
#(
  parameter int BIT_CYC = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  output logic       rxValid,
  output logic [7:0] rxData,
  output logic       rxFrameErr
);
  localparam int CW = $clog2(BIT_CYC);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYC / 2 - 1);
  logic meta_q, sync_q, prev_q, valid_q, valid_d, err_q, err_d;
  logic [1:0] vld_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  rx_state_e st_q, st_d;
  // prev_q only reports a high once the synchroniser holds real post-reset samples,
  // so a line held low across reset release is not mistaken for a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      vld_q   <= '0;
      prev_q  <= 1'b0;
      st_q    <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      meta_q  <= rs232_rx;
      sync_q  <= meta_q;
      vld_q   <= {vld_q[0], 1'b1};
      prev_q  <= vld_q[1] & sync_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (st_q)
      R_IDLE: begin
        cnt_d = '0;
        st_d  = (prev_q && !sync_q) ? R_START : R_IDLE;
      end
      R_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        st_d  = sync_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sh_d  = {sync_q, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        st_d  = (bit_q == 3'd7) ? R_STOP : R_DATA;
      end
      R_STOP: if (cnt_q == FULL) begin
        st_d    = R_IDLE;
        valid_d = sync_q;
        err_d   = !sync_q;
      end
      default: st_d = R_IDLE;
    endcase
  end
  assign rxValid    = valid_q;
  assign rxData     = sh_q;
  assign rxFrameErr = err_q;
endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: decodes host command bytes into request pulses and assembles 16-byte setting writes
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rs232_rx,
  output logic         corrTest,
  output logic         corrReadCF,
  output logic         corrReadSetting,
  output logic         corrReadCps,
  output logic [127:0] setting,
  output logic         settingWr,
  output logic         cmdErr
);
  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYC);
  logic rx_valid, rx_err;
  logic [7:0] rx_data;
  dec_state_e st_q, st_d;
  logic [3:0] cnt_q, cnt_d;
  logic [127:0] shadow_q, shadow_d, setting_q, setting_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic test_q, test_d, cf_q, cf_d, rset_q, rset_d, cps_q, cps_d, wr_q, wr_d, err_q, err_d;
  uart_rx_byte #(.BIT_CYC(BIT_CYC)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs232_rx  (rs232_rx),
    .rxValid   (rx_valid),
    .rxData    (rx_data),
    .rxFrameErr(rx_err)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= D_IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      setting_q <= '0;
      tmo_q     <= '0;
      test_q    <= 1'b0;
      cf_q      <= 1'b0;
      rset_q    <= 1'b0;
      cps_q     <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      setting_q <= setting_d;
      tmo_q     <= tmo_d;
      test_q    <= test_d;
      cf_q      <= cf_d;
      rset_q    <= rset_d;
      cps_q     <= cps_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
    end
  end
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    setting_d = setting_q;
    tmo_d     = (st_q != D_PAYLOAD || rx_valid) ? '0 : (tmo_q == TMO ? tmo_q : tmo_q + 1'b1);
    test_d    = 1'b0;
    cf_d      = 1'b0;
    rset_d    = 1'b0;
    cps_d     = 1'b0;
    wr_d      = 1'b0;
    err_d     = 1'b0;
    unique case (st_q)
      D_IDLE: if (rx_err) err_d = 1'b1;
      else if (rx_valid) begin
        test_d = rx_data == CMD_TEST;
        cf_d   = rx_data == CMD_READCF;
        rset_d = rx_data == CMD_READSET;
        cps_d  = rx_data == CMD_READCPS;
        err_d  = !is_known(rx_data);
        st_d   = (rx_data == CMD_WRSET) ? D_PAYLOAD : D_IDLE;
        cnt_d  = '0;
      end
      D_PAYLOAD: if (rx_err) begin
        err_d = 1'b1;
        st_d  = D_IDLE;
      end else if (rx_valid) begin
        shadow_d = {shadow_q[119:0], rx_data};
        cnt_d    = cnt_q + 1'b1;
        st_d     = (cnt_q == 4'(SETTING_BYTES - 1)) ? D_COMMIT : D_PAYLOAD;
      end else if (tmo_q == TMO) begin
        err_d = 1'b1;
        st_d  = D_IDLE;
      end
      D_COMMIT: begin
        setting_d = shadow_q;
        wr_d      = 1'b1;
        st_d      = D_IDLE;
      end
      default: st_d = D_IDLE;
    endcase
  end
  assign corrTest        = test_q;
  assign corrReadCF      = cf_q;
  assign corrReadSetting = rset_q;
  assign corrReadCps     = cps_q;
  assign setting         = setting_q;
  assign settingWr       = wr_q;
  assign cmdErr          = err_q;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: randomized serial stimulus checked against a byte-level behavioural model of the decoder
module tb_uart_cmd_rx;
  localparam int CF  = 1_600_000;
  localparam int BD  = 100_000;
  localparam int BIT = CF / BD;
  localparam int TMO = 3000;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic corrTest, corrReadCF, corrReadSetting, corrReadCps, settingWr, cmdErr;
  logic [127:0] setting;
  always #5 clk = ~clk;
  uart_cmd_rx #(.CLK_FREQ(CF), .BAUD(BD), .TIMEOUT_CYC(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs232_rx       (rx),
    .corrTest       (corrTest),
    .corrReadCF     (corrReadCF),
    .corrReadSetting(corrReadSetting),
    .corrReadCps    (corrReadCps),
    .setting        (setting),
    .settingWr      (settingWr),
    .cmdErr         (cmdErr)
  );
  typedef struct {
    int           kind;
    logic [127:0] val;
    longint       dl;
  } ev_t;
  ev_t q[$];
  int checks = 0, errors = 0;
  int cnt[6] = '{default: 0};
  longint cyc = 0;
  bit mon_en = 1'b0;
  logic [127:0] exp_set = '0;
  bit m_pay = 1'b0;
  int m_n = 0;
  logic [127:0] m_sh = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic int total();
    return cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4] + cnt[5];
  endfunction
  // kinds: 0 test, 1 readCF, 2 readSetting, 3 readCps, 4 settingWr, 5 cmdErr
  function automatic void push(input int k, input logic [127:0] v, input longint dl);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.dl   = dl;
    q.push_back(e);
  endfunction
  function automatic void model_byte(input logic [7:0] d, input bit ok, input longint dl);
    if (!ok) begin
      m_pay = 1'b0;
      push(5, '0, dl);
    end else if (m_pay) begin
      m_sh = {m_sh[119:0], d};
      m_n++;
      if (m_n == 16) begin
        m_pay = 1'b0;
        push(4, m_sh, dl);
      end
    end else if (d == 8'h57) begin
      m_pay = 1'b1;
      m_n   = 0;
    end
    else if (d == 8'h54) push(0, '0, dl);
    else if (d == 8'h43) push(1, '0, dl);
    else if (d == 8'h53) push(2, '0, dl);
    else if (d == 8'h50) push(3, '0, dl);
    else if (d != 8'h0D && d != 8'h0A) push(5, '0, dl);
  endfunction
  function automatic void model_timeout();
    if (m_pay) begin
      m_pay = 1'b0;
      push(5, '0, cyc + TMO + 60);
    end
  endfunction
  always @(negedge clk) begin : mon
    logic [5:0] p;
    ev_t e;
    if (rst_n && mon_en) begin
      p = {cmdErr, settingWr, corrReadCps, corrReadSetting, corrReadCF, corrTest};
      chk("onehot", 128'($countones(p) <= 1), 128'd1);
      for (int k = 0; k < 6; k++) if (p[k]) begin
        cnt[k]++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got kind %0d expected none at cycle %0d", k, cyc);
        end else begin
          e = q.pop_front();
          chk("event_kind", 128'(k), 128'(e.kind));
          if (k == 4) begin
            chk("commit_value", setting, e.val);
            exp_set = e.val;
          end
        end
      end
      chk("setting_hold", setting, exp_set);
      if (q.size() != 0 && cyc > q[0].dl) begin
        checks++;
        errors++;
        $display("FAIL missing_event: got none expected kind %0d by cycle %0d", q[0].kind, q[0].dl);
        void'(q.pop_front());
      end
    end
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input bit ok = 1'b1);
    model_byte(d, ok, cyc + 10 * BIT + BIT / 2 + 8);
    rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(BIT);
    end
    rx = ok;
    wait_cyc(BIT);
    rx = 1'b1;
  endtask
  initial begin
    int t0;
    logic [7:0] b;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
    mon_en = 1'b1;
    chk("rst_setting", setting, '0);
    chk("rst_pulses", 128'({corrTest, corrReadCF, corrReadSetting, corrReadCps, settingWr, cmdErr}), '0);
    send(8'h54);
    send(8'h43);
    wait_cyc(2 * BIT);
    chk("test_cnt", 128'(cnt[0]), 128'd1);
    chk("cf_cnt", 128'(cnt[1]), 128'd1);
    chk("first_total", 128'(total()), 128'd2);
    send(8'h57);
    for (int i = 0; i < 16; i++) send(8'(i));
    wait_cyc(2 * BIT);
    chk("wr_ramp", setting, 128'h000102030405060708090A0B0C0D0E0F);
    chk("wr_cnt1", 128'(cnt[4]), 128'd1);
    send(8'h57);
    for (int i = 0; i < 16; i++) send(8'h53);
    wait_cyc(2 * BIT);
    chk("wr_53", setting, {16{8'h53}});
    chk("no_readset", 128'(cnt[2]), 128'd0);
    chk("wr_cnt2", 128'(cnt[4]), 128'd2);
    send(8'h57);
    for (int i = 0; i < 5; i++) send(8'($urandom));
    model_timeout();
    wait_cyc(TMO + 100);
    chk("timeout_err", 128'(cnt[5]), 128'd1);
    chk("timeout_keep", setting, {16{8'h53}});
    send(8'h50);
    wait_cyc(2 * BIT);
    chk("cps_after_tmo", 128'(cnt[3]), 128'd1);
    send(8'h54, 1'b0);
    wait_cyc(2 * BIT);
    chk("frame_err", 128'(cnt[5]), 128'd2);
    chk("frame_no_test", 128'(cnt[0]), 128'd1);
    t0 = total();
    rx = 1'b0;
    wait_cyc(BIT * 3 / 10);
    rx = 1'b1;
    wait_cyc(3 * BIT);
    chk("glitch_quiet", 128'(total()), 128'(t0));
    send(8'h0D);
    send(8'h0A);
    send(8'h41);
    wait_cyc(2 * BIT);
    chk("crlf_err", 128'(cnt[5]), 128'd3);
    chk("crlf_total", 128'(total()), 128'(t0 + 1));
    send(8'h57);
    for (int i = 0; i < 9; i++) send(8'($urandom));
    rx = 1'b0;
    wait_cyc(5 * BIT);
    #3 rst_n = 1'b0;
    q.delete();
    exp_set = '0;
    m_pay = 1'b0;
    wait_cyc(3);
    chk("async_clear", setting, '0);
    rst_n = 1'b1;
    wait_cyc(3 * BIT);
    rx = 1'b1;
    wait_cyc(2 * BIT);
    chk("rst_setting0", setting, '0);
    chk("rst_no_wr", 128'(cnt[4]), 128'd2);
    send(8'h54);
    wait_cyc(2 * BIT);
    chk("test_after_rst", 128'(cnt[0]), 128'd2);
    for (int n = 0; n < 150; n++) begin
      int r;
      bit ok;
      r = $urandom_range(0, 9);
      b = (r == 0) ? 8'h54 : (r == 1) ? 8'h43 : (r == 2) ? 8'h53 : (r == 3) ? 8'h50 :
          (r == 4) ? 8'h57 : (r == 5) ? (($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A) : 8'($urandom);
      ok = $urandom_range(0, 19) != 0;
      send(b, ok);
      wait_cyc(BIT * (ok ? $urandom_range(0, 2) : 1 + $urandom_range(0, 1)));
    end
    model_timeout();
    wait_cyc(TMO + 100);
    chk("queue_drained", 128'(q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Receive-side command decoder for the correlator's PC link. It deserialises 8N1 bytes from `rs232_rx`, decodes single-byte host commands into one-cycle request pulses (`corrTest`, `corrReadCF`, `corrReadSetting`, `corrReadCps`) consumed by the upload block, and assembles a 16-byte write-setting payload into the 128-bit `setting` register. It sits between the board RX pin and the correlator core / upload path.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 115200, line rate; bit period `BIT_CYC = CLK_FREQ/BAUD` (434), integer-truncated.
- `TIMEOUT_CYC`, 5_000_000, maximum idle gap between payload bytes (100 ms).
- `clk` in 1 — 50 MHz main clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `rs232_rx` in 1 — asynchronous serial input, idle high.
- `corrTest` out 1 — one-cycle pulse on command 'T' (0x54).
- `corrReadCF` out 1 — one-cycle pulse on 'C' (0x43).
- `corrReadSetting` out 1 — one-cycle pulse on 'S' (0x53).
- `corrReadCps` out 1 — one-cycle pulse on 'P' (0x50).
- `setting` out 128 — current setting; updates atomically on a completed 'W' frame.
- `settingWr` out 1 — one-cycle pulse, cycle in which `setting` takes its new value.
- `cmdErr` out 1 — one-cycle pulse on framing error, unknown command or payload timeout.

Reset values: all pulse outputs 0, `setting` = 128'h0.

## Operation
- RX front end: `rs232_rx` through 2-FF synchroniser (reset to 1). Falling edge in RX idle starts a frame; start bit re-checked at `BIT_CYC/2`; if high, false start, return to idle, no error. Data bits sampled every `BIT_CYC` thereafter, LSB first; stop bit sampled at its midpoint. Stop = 1 -> `rxValid` pulse with `rxData`; stop = 0 -> byte discarded, framing error flagged.
- Decoder FSM states: `D_IDLE`, `D_PAYLOAD`, `D_COMMIT`.
- `D_IDLE` on `rxValid`: 'T','C','S','P' -> matching pulse; 'W' (0x57) -> clear byte counter, go `D_PAYLOAD`; 0x0D, 0x0A -> ignored; any other value -> `cmdErr`.
- `D_PAYLOAD`: each `rxValid` shifts byte into 128-bit shadow, MSB first (first byte lands in [127:120]); counter 0..15; on 16th byte go `D_COMMIT`. Command letters are data here, not decoded.
- `D_COMMIT`: `setting <= shadow`, `settingWr` = 1, back to `D_IDLE` (single cycle).
- Timeout: counter cleared on entry to `D_PAYLOAD` and on each `rxValid`; reaching `TIMEOUT_CYC` in `D_PAYLOAD` -> `cmdErr`, `D_IDLE`, `setting` unchanged, shadow discarded.
- Framing error in any decoder state -> `cmdErr`; in `D_PAYLOAD` also aborts to `D_IDLE` without commit.
- At most one of the four command pulses asserted per cycle; `cmdErr` never coincident with a command pulse or `settingWr`.

## Timing
- `rxValid` asserted the cycle after the stop-bit sample; command pulse / `cmdErr` registered the cycle after `rxValid` (2 cycles after stop sample).
- `settingWr` and new `setting` visible 2 cycles after the 16th byte's `rxValid`.
- Back-to-back bytes (stop bit immediately followed by start) must be received without loss; RX returns to idle-watch right after the stop sample.
- Asynchronous reset mid-frame: RX and decoder return to idle, partial payload lost, `setting` cleared to 0; a line-low at reset release is not a start edge until a high is seen.
- Sample counter width `$clog2(BIT_CYC)`; timeout counter width `$clog2(TIMEOUT_CYC+1)`, saturating.

## Structure
- Shared package: command byte constants (`CMD_TEST`, `CMD_READCF`, `CMD_READSET`, `CMD_READCPS`, `CMD_WRSET`), `SETTING_BYTES = 16`, decoder state encoding.
- One sub-module: `uart_rx_byte` (synchroniser, bit timer, shifter; outputs `rxValid`, `rxData`, `rxFrameErr`). Decoder FSM, shadow register and timeout live in the top.

## Test plan
- Send 0x54, then 0x43 -> exactly one `corrTest` pulse, then one `corrReadCF` pulse; no other outputs.
- Send 'W' + 0x00..0x0F -> `settingWr` once, `setting` = 128'h000102030405060708090A0B0C0D0E0F; 'W'+16×0x53 writes 0x53… without any `corrReadSetting`.
- Send 'W' + 5 bytes, then silence > `TIMEOUT_CYC` -> one `cmdErr`, `setting` unchanged, following 'P' gives `corrReadCps`.
- Byte 0x54 with stop bit forced 0 -> `cmdErr`, no `corrTest`; 0.3-bit low glitch -> no output.
- Send 0x0D, 0x0A, 0x41 -> only one `cmdErr` (for 0x41).
- Assert `rst_n` low during 10th payload byte -> `setting` = 0, no `settingWr`; subsequent 'T' decodes normally.
